elevator_scan_ctrl: RTL and testbench

//  Parametrised single-car elevator controller (SCAN scheduling) driving the elevator plant.

---
 rtl/elevator_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
`timescale 1ns/1ps
// elevator_pkg / elevator_scan_ctrl
// Purpose : single-car SCAN elevator controller. Latches floor requests into
//           lights, sequences engine/direction/doors, adds door dwell/hold,
//           idle parking at a home floor, emergency stop and position-fault
//           detection.
// Ports   : clk, rst (async, active-high)
//           requestFloor [FLOORS] request pulses (bitmap, bit0 = ground)
//           currentFloor [FLOORS] plant position, one-hot
//           doorHold             restarts dwell while doors are open
//           estop                emergency stop, level
//           floorLight   [FLOORS] pending-request lights (registered)
//           direction/doorsOp/engineOp  plant commands (registered)
//           fault                sticky: position not one-hot

package elevator_pkg;
   typedef enum logic {UP = 1'b0, DOWN = 1'b1} Direction;
   typedef enum logic {CLOSE = 1'b0, OPEN = 1'b1} DoorsOp;
   typedef enum logic {STOP = 1'b0, GO = 1'b1} EngineOp;
endpackage

module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS      = 5,
   parameter int unsigned DOOR_CYCLES = 4,
   parameter int unsigned PARK_EN     = 1,
   parameter int unsigned PARK_CYCLES = 32,
   parameter int unsigned HOME_FLOOR  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLOORS-1:0] requestFloor,
   input  logic [FLOORS-1:0] currentFloor,
   input  logic              doorHold,
   input  logic              estop,
   output logic [FLOORS-1:0] floorLight,
   output Direction          direction,
   output DoorsOp            doorsOp,
   output EngineOp           engineOp,
   output logic              fault
);

   localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam int unsigned IW = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
   localparam logic [DW-1:0]     DWELL_LOAD = DW'(DOOR_CYCLES - 1);
   localparam logic [IW-1:0]     IDLE_LAST  = IW'(PARK_CYCLES - 1);
   localparam logic [FLOORS-1:0] HOME_OH    = FLOORS'(1) << HOME_FLOOR;

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_OPEN, S_HALT} state_t;

   state_t            r_state,  w_state_nxt;
   logic              r_park,   w_park_nxt;
   logic [DW-1:0]     r_dwell,  w_dwell_nxt;
   logic [IW-1:0]     r_idle,   w_idle_nxt;
   logic [FLOORS-1:0] w_lights_nxt;
   Direction          w_dir_nxt;
   DoorsOp            w_doors_nxt;
   EngineOp           w_eng_nxt;
   logic              w_fault_nxt;

   // Request/position decode
   logic [FLOORS-1:0] w_lights, w_below, w_above, w_nf, w_nf_below, w_nf_above;
   logic w_onehot, w_here, w_any_above, w_any_below, w_nf_lit, w_nf_end;
   logic w_beyond, w_any_light, w_park_eff, w_home_up, w_same_req, w_ahead, w_behind;

   always_comb begin
      w_lights    = floorLight | requestFloor;
      w_onehot    = (currentFloor != '0) &&
                    ((currentFloor & (currentFloor - FLOORS'(1))) == '0);
      w_below     = currentFloor - FLOORS'(1);
      w_above     = ~(w_below | currentFloor);
      w_here      = |(w_lights & currentFloor);
      w_any_above = |(w_lights & w_above);
      w_any_below = |(w_lights & w_below);
      w_ahead     = (direction == UP) ? w_any_above : w_any_below;
      w_behind    = (direction == UP) ? w_any_below : w_any_above;
      // Floor the car reaches at the end of this cycle's move
      w_nf        = (direction == UP) ? (currentFloor << 1) : (currentFloor >> 1);
      w_nf_below  = w_nf - FLOORS'(1);
      w_nf_above  = ~(w_nf_below | w_nf);
      w_nf_lit    = |(w_lights & w_nf);
      w_nf_end    = (w_nf == '0) ||
                    ((direction == UP) ? w_nf[FLOORS-1] : w_nf[0]);
      w_beyond    = (direction == UP) ? |(w_lights & w_nf_above)
                                      : |(w_lights & w_nf_below);
      w_any_light = |w_lights;
      // Any pending light cancels a park trip
      w_park_eff  = r_park && !w_any_light;
      w_home_up   = HOME_OH > currentFloor;
      w_same_req  = |(requestFloor & currentFloor);
   end

   // Next-state and output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_dir_nxt    = direction;
      w_doors_nxt  = CLOSE;
      w_eng_nxt    = STOP;
      w_lights_nxt = w_lights;
      w_park_nxt   = w_park_eff;
      w_dwell_nxt  = r_dwell;
      w_idle_nxt   = '0;
      w_fault_nxt  = fault;

      if (!w_onehot) begin
         w_fault_nxt = 1'b1;
         w_state_nxt = S_HALT;
      end else if (fault || estop) begin
         w_state_nxt = S_HALT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_here) begin
                  w_state_nxt  = S_OPEN;
                  w_doors_nxt  = OPEN;
                  w_lights_nxt = w_lights & ~currentFloor;
                  w_dwell_nxt  = DWELL_LOAD;
               end else if (w_ahead) begin
                  w_state_nxt = S_MOVE;
                  w_eng_nxt   = GO;
               end else if (w_behind) begin
                  // Flip and GO leave the register together; engine is STOP now
                  w_dir_nxt   = (direction == UP) ? DOWN : UP;
                  w_state_nxt = S_MOVE;
                  w_eng_nxt   = GO;
               end else if ((PARK_EN != 0) && (r_idle == IDLE_LAST) &&
                            (currentFloor != HOME_OH)) begin
                  w_park_nxt  = 1'b1;
                  w_dir_nxt   = w_home_up ? UP : DOWN;
                  w_state_nxt = S_MOVE;
                  w_eng_nxt   = GO;
               end else begin
                  w_idle_nxt = (r_idle == IDLE_LAST) ? r_idle : r_idle + IW'(1);
               end
            end
            S_MOVE: begin
               if (w_nf_lit) begin
                  w_state_nxt  = S_OPEN;
                  w_doors_nxt  = OPEN;
                  w_lights_nxt = w_lights & ~w_nf;
                  w_dwell_nxt  = DWELL_LOAD;
                  w_park_nxt   = 1'b0;
               end else if (w_nf_end || (w_park_eff && (w_nf == HOME_OH)) ||
                            (!w_park_eff && !w_beyond)) begin
                  // End floor, park target, or nothing left ahead: stop, doors shut
                  w_state_nxt = S_IDLE;
                  w_park_nxt  = 1'b0;
               end else begin
                  w_eng_nxt = GO;
               end
            end
            S_OPEN: begin
               w_doors_nxt  = OPEN;
               w_lights_nxt = w_lights & ~currentFloor;
               if (doorHold || w_same_req) begin
                  w_dwell_nxt = DWELL_LOAD;
               end else if (r_dwell == '0) begin
                  w_doors_nxt = CLOSE;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_dwell_nxt = r_dwell - DW'(1);
               end
            end
            S_HALT: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_park     <= 1'b0;
         r_dwell    <= '0;
         r_idle     <= '0;
         floorLight <= '0;
         direction  <= UP;
         doorsOp    <= CLOSE;
         engineOp   <= STOP;
         fault      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_park     <= w_park_nxt;
         r_dwell    <= w_dwell_nxt;
         r_idle     <= w_idle_nxt;
         floorLight <= w_lights_nxt;
         direction  <= w_dir_nxt;
         doorsOp    <= w_doors_nxt;
         engineOp   <= w_eng_nxt;
         fault      <= w_fault_nxt;
      end
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
`timescale 1ns/1ps
// tb_elevator_scan_ctrl
// Purpose : directed bench for elevator_scan_ctrl with a one-floor-per-cycle
//           plant model and a continuous safety monitor.
module tb_elevator_scan_ctrl;
   import elevator_pkg::*;

   logic       clk, rst;
   logic [4:0] req, cur, set_val;
   logic       set_req, hold, estop;
   logic [4:0] floorLight;
   Direction   direction;
   DoorsOp     doorsOp;
   EngineOp    engineOp;
   logic       fault;

   int n_tests = 0;
   int n_fail  = 0;
   int viol    = 0;

   elevator_scan_ctrl dut (
      .clk(clk), .rst(rst), .requestFloor(req), .currentFloor(cur),
      .doorHold(hold), .estop(estop), .floorLight(floorLight),
      .direction(direction), .doorsOp(doorsOp), .engineOp(engineOp),
      .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plant: moves one floor per cycle while GO; bench can place the car
   always @(posedge clk) begin
      if (set_req)            cur <= set_val;
      else if (engineOp == GO) cur <= (direction == UP) ? (cur << 1) : (cur >> 1);
   end

   // Safety monitor
   EngineOp  prev_eng;
   DoorsOp   prev_doors;
   Direction prev_dir;
   logic     prev_valid = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (engineOp == GO && doorsOp == OPEN) viol++;
         if (engineOp == GO && direction == DOWN && cur[0]) viol++;
         if (engineOp == GO && direction == UP && cur[4]) viol++;
         if (prev_valid && prev_eng == GO && engineOp == GO && direction != prev_dir) viol++;
         if (prev_valid && prev_doors == OPEN && engineOp == GO) viol++;
         prev_eng   = engineOp;
         prev_doors = doorsOp;
         prev_dir   = direction;
         prev_valid = 1'b1;
      end
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [4:0] pos);
      rst = 1'b1; set_req = 1'b1; set_val = pos;
      req = '0; hold = 1'b0; estop = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      set_req = 1'b0;
      rst = 1'b0;
   endtask

   int cnt, bad;

   initial begin
      cur = 5'b00001;
      // T1: ground to top
      do_reset(5'b00001);
      check("rst_engine", engineOp, STOP);
      check("rst_doors", doorsOp, CLOSE);
      check("rst_dir", direction, UP);
      check("rst_lights", floorLight, 0);
      check("rst_fault", fault, 0);
      req = 5'b10000; tick(); req = '0;
      check("t1_go", engineOp, GO);
      check("t1_up", direction, UP);
      check("t1_light", floorLight, 5'b10000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_still_go", engineOp, GO);
      end
      tick();
      check("t1_stop", engineOp, STOP);
      check("t1_open", doorsOp, OPEN);
      check("t1_cur", cur, 5'b10000);
      check("t1_light_clr", floorLight, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_dwell_open", doorsOp, OPEN);
      end
      tick();
      check("t1_close", doorsOp, CLOSE);

      // T2: serve bit4 then reverse to bit0
      do_reset(5'b00100);
      req = 5'b10000; tick(); req = 5'b00001;
      check("t2_go_up", engineOp, GO);
      tick(); req = '0;
      check("t2_lights", floorLight, 5'b10001);
      check("t2_cur3", cur, 5'b01000);
      tick();
      check("t2_open4", doorsOp, OPEN);
      check("t2_cur4", cur, 5'b10000);
      check("t2_light_left", floorLight, 5'b00001);
      repeat (3) tick();
      check("t2_still_open", doorsOp, OPEN);
      tick();
      check("t2_close", doorsOp, CLOSE);
      check("t2_stop_gap", engineOp, STOP);
      check("t2_dir_held", direction, UP);
      tick();
      check("t2_go_down", engineOp, GO);
      check("t2_dir_down", direction, DOWN);
      repeat (3) tick();
      check("t2_cur1", cur, 5'b00010);
      tick();
      check("t2_open0", doorsOp, OPEN);
      check("t2_cur0", cur, 5'b00001);
      check("t2_lights_clr", floorLight, 0);

      // T3: door hold
      do_reset(5'b00010);
      req = 5'b00010; tick(); req = '0; hold = 1'b1;
      check("t3_open", doorsOp, OPEN);
      check("t3_no_light", floorLight, 0);
      cnt = 1; bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 9) hold = 1'b0;
         if (doorsOp == OPEN) cnt++;
         if (engineOp != STOP) bad++;
      end
      check("t3_open_cycles", cnt, 14);
      check("t3_engine_stop", bad, 0);

      // T4: park from bit3 to home bit0
      do_reset(5'b01000);
      cnt = 0;
      for (int i = 0; i < 31; i++) begin
         tick();
         if (engineOp == GO) cnt++;
      end
      check("t4_idle_wait", cnt, 0);
      tick();
      check("t4_go", engineOp, GO);
      check("t4_down", direction, DOWN);
      repeat (2) tick();
      check("t4_moving", engineOp, GO);
      tick();
      check("t4_stop", engineOp, STOP);
      check("t4_doors", doorsOp, CLOSE);
      check("t4_home", cur, 5'b00001);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (engineOp == GO) cnt++;
      end
      check("t4_parked", cnt, 0);

      // T5: estop mid-move
      do_reset(5'b00001);
      req = 5'b10000; tick(); req = '0;
      repeat (2) tick();
      check("t5_cur2", cur, 5'b00100);
      estop = 1'b1; tick();
      check("t5_halt_stop", engineOp, STOP);
      check("t5_halt_close", doorsOp, CLOSE);
      check("t5_cur3", cur, 5'b01000);
      req = 5'b00001; tick(); req = '0;
      repeat (2) tick();
      check("t5_still_stop", engineOp, STOP);
      check("t5_lights_kept", floorLight, 5'b10001);
      estop = 1'b0; tick();
      check("t5_idle_stop", engineOp, STOP);
      tick();
      check("t5_resume_go", engineOp, GO);
      check("t5_resume_up", direction, UP);
      tick();
      check("t5_arrive_open", doorsOp, OPEN);
      check("t5_arrive_cur", cur, 5'b10000);
      check("t5_arrive_light", floorLight, 5'b00001);

      // T6: position fault
      do_reset(5'b00001);
      set_req = 1'b1; set_val = 5'b00110; tick(); set_req = 1'b0;
      tick();
      check("t6_fault", fault, 1);
      check("t6_stop", engineOp, STOP);
      set_req = 1'b1; set_val = 5'b00001; req = 5'b10000; tick();
      set_req = 1'b0; req = '0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (engineOp == GO) cnt++;
      end
      check("t6_no_go", cnt, 0);
      check("t6_sticky", fault, 1);
      do_reset(5'b00001);
      check("t6_rst_clr", fault, 0);
      req = 5'b00100; tick(); req = '0;
      check("t6_recover_go", engineOp, GO);

      check("safety_monitor", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
